// File: rtl/minus_pipe_pkg.sv
// ============================================================================
// Package : minus_pipe_pkg
// Brief   : Shared datapath widths, port types and lambda mode encoding.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package minus_pipe_pkg;

    localparam int c_MAG_W    = 14;
    localparam int c_PHI_W    = 14;
    localparam int c_RHO_W    = 8;
    localparam int c_RHO_FRAC = 7;
    localparam int c_LAMBDA_W = 14;
    localparam int c_DEPTH    = 6;
    localparam int c_CNT_W    = 16;

    typedef logic signed [c_MAG_W-1:0]    mag_t;
    typedef logic        [c_PHI_W-1:0]    phi_t;
    typedef logic signed [c_RHO_W-1:0]    rho_t;
    typedef logic signed [c_LAMBDA_W-1:0] lambda_t;

    typedef enum logic {
        LAM_WRAP = 1'b0,
        LAM_SAT  = 1'b1
    } lambda_mode_e;

endpackage

`default_nettype wire

// File: rtl/minus_pipe_if.sv
// ============================================================================
// Interface : minus_pipe_if
// Brief     : Input/output handshakes and statistics of the lambda pipeline.
// Rev       : 1.0  initial release
// ============================================================================
`default_nettype none

interface minus_pipe_if
    import minus_pipe_pkg::*;
#(
    parameter int MAG_W = c_MAG_W,
    parameter int PHI_W = c_PHI_W,
    parameter int RHO_W = c_RHO_W,
    parameter int OUT_W = c_LAMBDA_W,
    parameter int CNT_W = c_CNT_W
);
    logic             in_valid;
    logic             in_ready;
    logic [MAG_W-1:0] mag_in;
    logic [PHI_W-1:0] phi_in;
    logic [RHO_W-1:0] rho_in;
    logic             sat_mode;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] lambda_out;
    logic             out_ovf;
    logic             clr_stats;
    logic [CNT_W-1:0] ovf_cnt;

    modport master (
        output in_valid, mag_in, phi_in, rho_in, sat_mode, out_ready, clr_stats,
        input  in_ready, out_valid, lambda_out, out_ovf, ovf_cnt
    );

    modport slave (
        input  in_valid, mag_in, phi_in, rho_in, sat_mode, out_ready, clr_stats,
        output in_ready, out_valid, lambda_out, out_ovf, ovf_cnt
    );
endinterface

`default_nettype wire

// File: rtl/minus_pipe_elastic_stage.sv
// ============================================================================
// Module : elastic_stage
// Brief  : One valid/ready register slice; ready is computed by the parent.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module elastic_stage #(
    parameter int W = 8
) (
    input  wire logic         clk,
    input  wire logic         rst,
    input  wire logic         in_valid,
    input  wire logic [W-1:0] in_data,
    output logic              out_valid,
    output logic [W-1:0]      out_data,
    input  wire logic         out_ready
);
    logic         r_valid;
    logic [W-1:0] r_data;
    logic         w_load;

    assign w_load = in_valid && (!r_valid || out_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (w_load) begin
            r_valid <= 1'b1;
            r_data  <= in_data;
        end else if (out_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign out_valid = r_valid;
    assign out_data  = r_data;
endmodule

`default_nettype wire

// File: rtl/minus_pipe.sv
// ============================================================================
// Module : minus_pipe
// Brief  : lambda = mag - rho*phi with wrap/saturate, elastic pipeline, ovf count.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module minus_pipe
    import minus_pipe_pkg::*;
#(
    parameter int MAG_W    = c_MAG_W,
    parameter int PHI_W    = c_PHI_W,
    parameter int RHO_W    = c_RHO_W,
    parameter int RHO_FRAC = c_RHO_FRAC,
    parameter int OUT_W    = c_LAMBDA_W,
    parameter int DEPTH    = c_DEPTH,
    parameter int CNT_W    = c_CNT_W
) (
    input wire logic    clk,
    input wire logic    rst,
    minus_pipe_if.slave bus
);
    localparam int c_PW    = RHO_W + PHI_W + 1;
    localparam int c_DW    = c_PW + 1;
    localparam int c_PAY_W = OUT_W + 1;
    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;

    logic signed [c_PW-1:0] w_rho_x, w_phi_x, w_prod, w_ps;
    logic signed [c_DW-1:0] w_mag_x, w_d;
    logic [c_DW-OUT_W:0]    w_hi;
    logic                   w_ovf;
    logic [OUT_W-1:0]       w_lam;
    lambda_mode_e           w_mode;

    assign w_rho_x = c_PW'($signed(bus.rho_in));
    assign w_phi_x = c_PW'({1'b0, bus.phi_in});
    assign w_prod  = w_rho_x * w_phi_x;
    assign w_ps    = w_prod >>> RHO_FRAC;
    assign w_mag_x = c_DW'($signed(bus.mag_in));
    assign w_d     = w_mag_x - c_DW'(w_ps);

    // Result fits OUT_W only if every bit above the OUT_W sign bit matches it
    assign w_hi   = w_d[c_DW-1:OUT_W-1];
    assign w_ovf  = (|w_hi) & ~(&w_hi);
    assign w_mode = lambda_mode_e'(bus.sat_mode);

    always_comb begin
        w_lam = w_d[OUT_W-1:0];
        if (w_mode == LAM_SAT && w_ovf) begin
            w_lam = w_d[c_DW-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
        end
    end

    logic [DEPTH-1:0]   w_sv;
    logic [c_PAY_W-1:0] w_sd [DEPTH];
    logic [DEPTH:0]     w_rdy;
    logic               w_accept;

    // Stage i can load when any stage from i to the tail has a hole, or the tail drains
    assign w_rdy[DEPTH] = bus.out_ready;

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic               w_iv;
        logic [c_PAY_W-1:0] w_id;

        assign w_rdy[i] = bus.out_ready | ~(&w_sv[DEPTH-1:i]);

        if (i == 0) begin : g_first
            assign w_iv = bus.in_valid && !rst;
            assign w_id = {w_lam, w_ovf};
        end else begin : g_rest
            assign w_iv = w_sv[i-1];
            assign w_id = w_sd[i-1];
        end

        elastic_stage #(.W(c_PAY_W)) u_stage (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (w_iv),
            .in_data   (w_id),
            .out_valid (w_sv[i]),
            .out_data  (w_sd[i]),
            .out_ready (w_rdy[i+1])
        );
    end

    assign bus.in_ready   = w_rdy[0] && !rst;
    assign bus.out_valid  = w_sv[DEPTH-1] && !rst;
    assign bus.lambda_out = w_sd[DEPTH-1][c_PAY_W-1:1];
    assign bus.out_ovf    = w_sd[DEPTH-1][0];

    assign w_accept = bus.in_valid && bus.in_ready;

    logic [CNT_W-1:0] r_ovf_cnt;

    always_ff @(posedge clk) begin
        if (rst || bus.clr_stats) begin
            r_ovf_cnt <= '0;
        end else if (w_accept && w_ovf && r_ovf_cnt != c_CNT_MAX) begin
            r_ovf_cnt <= r_ovf_cnt + 1'b1;
        end
    end

    assign bus.ovf_cnt = r_ovf_cnt;
endmodule

`default_nettype wire

// File: tb/tb_minus_pipe.sv
// ============================================================================
// Module : tb_minus_pipe
// Brief  : Directed self-checking bench for minus_pipe.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_minus_pipe;
    import minus_pipe_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    minus_pipe_if bus ();

    minus_pipe dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_one(input string tag, input logic [13:0] m, input logic [13:0] p,
                           input logic [7:0] r, input logic s,
                           input logic [13:0] exp_l, input logic exp_o);
        int lat;
        bus.mag_in    = m;
        bus.phi_in    = p;
        bus.rho_in    = r;
        bus.sat_mode  = s;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        #1;
        chk({tag, "_rdy"}, 32'(bus.in_ready), 32'd1);
        tick();
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 20) begin
            tick();
            lat++;
        end
        chk({tag, "_lat"}, 32'(lat), 32'd6);
        chk({tag, "_lam"}, 32'(bus.lambda_out), 32'(exp_l));
        chk({tag, "_ovf"}, 32'(bus.out_ovf), 32'(exp_o));
        tick();
    endtask

    initial begin
        int sent, recv, acc, seen;
        logic prev_stall;
        logic [13:0] prev_lam;

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.mag_in    = '0;
        bus.phi_in    = '0;
        bus.rho_in    = '0;
        bus.sat_mode  = 1'b0;
        bus.out_ready = 1'b1;
        bus.clr_stats = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_lambda", 32'(bus.lambda_out), 32'd0);
        chk("rst_ovf", 32'(bus.out_ovf), 32'd0);
        chk("rst_cnt", 32'(bus.ovf_cnt), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);

        // Hand-computed arithmetic vectors
        run_one("basic", 14'd256, 14'd256, 8'd64, 1'b0, 14'h0080, 1'b0);
        run_one("floor", 14'd0, 14'd1, 8'hFF, 1'b0, 14'h0001, 1'b0);
        chk("cnt_none", 32'(bus.ovf_cnt), 32'd0);
        run_one("pos_sat", 14'h1FFF, 14'h3FFF, 8'h80, 1'b1, 14'h1FFF, 1'b1);
        run_one("pos_wrap", 14'h1FFF, 14'h3FFF, 8'h80, 1'b0, 14'h1FFE, 1'b1);
        run_one("neg_sat", 14'h2000, 14'h3FFF, 8'h7F, 1'b1, 14'h2000, 1'b1);
        run_one("neg_wrap", 14'h2000, 14'h3FFF, 8'h7F, 1'b0, 14'h2081, 1'b1);
        chk("cnt_four", 32'(bus.ovf_cnt), 32'd4);

        // Backpressure: fill with out_ready low, then drain with random out_ready
        bus.phi_in    = '0;
        bus.rho_in    = '0;
        bus.sat_mode  = 1'b0;
        bus.out_ready = 1'b0;
        sent = 0;
        for (int c = 0; c < 20; c++) begin
            bus.in_valid = 1'b1;
            bus.mag_in   = 14'(sent);
            #1;
            if (!bus.in_ready) break;
            sent++;
            @(posedge clk);
            #1;
        end
        chk("bp_fill", 32'(sent), 32'd6);
        recv = 0;
        prev_stall = 1'b0;
        prev_lam = '0;
        for (int c = 0; c < 400 && recv < 20; c++) begin
            bus.in_valid  = (sent < 20);
            bus.mag_in    = 14'(sent);
            bus.out_ready = (c == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            #1;
            if (c == 0) chk("bp_passthru", 32'(bus.in_ready), 32'd1);
            if (prev_stall) begin
                chk("bp_hold_v", 32'(bus.out_valid), 32'd1);
                chk("bp_hold_l", 32'(bus.lambda_out), 32'(prev_lam));
            end
            if (bus.out_valid && bus.out_ready) begin
                chk("bp_order", 32'(bus.lambda_out), 32'(recv));
                recv++;
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_lam   = bus.lambda_out;
            if (bus.in_valid && bus.in_ready) sent++;
            @(posedge clk);
            #1;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        chk("bp_sent", 32'(sent), 32'd20);
        chk("bp_recv", 32'(recv), 32'd20);
        repeat (8) tick();
        chk("bp_empty", 32'(bus.out_valid), 32'd0);

        // Reset with four samples in flight
        for (int k = 0; k < 4; k++) begin
            bus.in_valid = 1'b1;
            bus.mag_in   = 14'(100 + k);
            tick();
        end
        bus.in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        chk("mid_rst_cnt", 32'(bus.ovf_cnt), 32'd0);
        seen = 0;
        repeat (10) begin
            tick();
            if (bus.out_valid) seen++;
        end
        chk("mid_rst_stale", 32'(seen), 32'd0);

        // Counter saturation, then clear coincident with an overflowing accept
        bus.mag_in    = 14'h1FFF;
        bus.phi_in    = 14'h3FFF;
        bus.rho_in    = 8'h80;
        bus.sat_mode  = 1'b1;
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        #1;
        acc = 0;
        for (int c = 0; c < 70000 && acc < 65540; c++) begin
            if (bus.in_ready) acc++;
            tick();
        end
        chk("sat_accepts", 32'(acc), 32'd65540);
        chk("sat_cnt", 32'(bus.ovf_cnt), 32'h0000FFFF);
        bus.clr_stats = 1'b1;
        tick();
        bus.clr_stats = 1'b0;
        chk("clr_wins", 32'(bus.ovf_cnt), 32'd0);
        tick();
        chk("cnt_after_clr", 32'(bus.ovf_cnt), 32'd1);
        bus.mag_in = 14'd256;
        bus.phi_in = 14'd256;
        bus.rho_in = 8'd64;
        tick();
        bus.in_valid = 1'b0;
        chk("cnt_no_ovf", 32'(bus.ovf_cnt), 32'd1);
        repeat (8) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

`default_nettype wire
